ppi_port_a_handshake: RTL and testbench
=======================================

# ppi_port_a_handshake

Strobed (Mode 1) handshake controller for PPI Port A. It provides the peripheral-side counterpart to the CPU-side port data path. In input mode it latches peripheral data on STB and raises IBF and INTR. In output mode it holds CPU-written data, raises OBF, and completes the transfer on the peripheral's ACK. It sits between the control logic, which supplies direction, enable and single-cycle CPU read/write strobes, and the Port A pins.

## Interface
Parameters:
- WIDTH, 8, port data width.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- rst  in  1  reset, synchronous, active-high.
- enable  in  1  port is in Mode 1; when 0, the handshake state is held at reset values.
- dir_in  in  1  1 = strobed input, 0 = strobed output.
- inte  in  1  interrupt enable (INTE flip-flop value from the control logic).
- cpu_rd  in  1  one-cycle pulse: CPU reads Port A.
- cpu_wr  in  1  one-cycle pulse: CPU writes Port A.
- cpu_wdata  in  WIDTH  CPU write data, sampled when cpu_wr=1.
- cpu_rdata  out  WIDTH  read data for the CPU.
- pa_in  in  WIDTH  peripheral data, sampled on STB.
- pa_out  out  WIDTH  output latch driven to the pins.
- pa_oe  out  1  pin output enable.
- stb_n  in  1  peripheral strobe, active-low; already synchronous to clk.
- ack_n  in  1  peripheral acknowledge, active-low; already synchronous to clk.
- ibf  out  1  input buffer full.
- obf_n  out  1  output buffer full, active-low.
- intr  out  1  interrupt request.
- overrun  out  1  sticky flag: a strobe arrived while ibf=1.

## Operation
- Edge detection:
  - stb_n and ack_n are registered each cycle; the registers reset to 1.
  - A fall is the current sample 0 with the previous sample 1.
  - A rise is the current sample 1 with the previous sample 0.
- Input mode (enable=1, dir_in=1):
  - stb fall: in_latch<=pa_in, ibf<=1. If ibf was already 1, overrun<=1 and in_latch is still overwritten.
  - stb rise: intr<=1 if inte=1 and ibf=1.
  - cpu_rd: ibf<=0, intr<=0, overrun<=0.
  - cpu_rd and stb fall in the same cycle: the new data is latched, ibf=1, intr=0, and overrun is cleared.
  - cpu_wr is ignored.
- Output mode (enable=1, dir_in=0):
  - cpu_wr: out_latch<=cpu_wdata, obf_n<=0, intr<=0.
  - ack fall: obf_n<=1.
  - ack rise: intr<=1 if inte=1 and obf_n=1.
  - cpu_wr and ack fall in the same cycle: the write wins, so obf_n=0 and out_latch takes the new data.
  - ack rise with obf_n=0: no intr.
  - cpu_rd has no handshake effect.
- Outputs:
  - pa_out = out_latch at all times.
  - pa_oe = enable & ~dir_in.
  - cpu_rdata = in_latch when dir_in=1, out_latch otherwise.
- inte going to 0 clears intr on the next edge. Re-enabling inte does not raise intr until the next qualifying rise.
- Change of enable or dir_in:
  - Handshake state (ibf, obf_n, intr, overrun) returns to reset values on the next edge.
  - in_latch and out_latch are retained.

## Timing
- Reset values:
  - ibf=0, obf_n=1, intr=0, overrun=0.
  - in_latch=0, out_latch=0, so pa_out=0 and cpu_rdata=0.
  - Edge registers = 1.
  - pa_oe follows its combinational definition.
- Reset takes priority over every event. Reset during an open handshake (ibf=1 or obf_n=0) abandons it with no intr.
- Latency:
  - A strobe/ack level sampled low in cycle N (previous sample high) updates the flags and latch at the end of cycle N; they are visible in cycle N+1.
  - Rise-to-intr: intr is visible in the cycle after the rise is sampled.
  - cpu_rd/cpu_wr: effects are visible in the next cycle.
- Minimum strobe low time is 1 cycle. Back-to-back strobes are allowed every 2 cycles.
- No combinational path from stb_n or ack_n to any output.

## Structure
- Shared package ppi_pkg:
  - DIR_IN=1'b1, DIR_OUT=1'b0.
  - Default data width 8, shared with the other port blocks.
- Sub-module ppi_edge_det holds a one-flop sampler plus fall/rise pulses, with reset value 1. It is instantiated for stb_n and for ack_n.
- The handshake flags are plain registers in the top. No explicit FSM encoding is needed beyond ibf, obf_n and intr.

## Test plan
- Input with inte=1: pa_in=8'hA5, stb_n low 2 cycles then high. Expect ibf=1 in the cycle after the fall, intr=1 after the rise, cpu_rdata=A5. cpu_rd then clears ibf and intr next cycle.
- Output with inte=1:
  - cpu_wr with 8'h3C gives pa_out=3C, obf_n=0, pa_oe=1.
  - ack_n pulse low: obf_n=1 after the fall, intr=1 after the rise.
  - A second cpu_wr clears intr.
- Overrun and simultaneous events:
  - Two strobes (11, then 22) with no cpu_rd: cpu_rdata=22, overrun=1.
  - A later cpu_rd coincident with a third strobe (33): ibf=1, intr=0, overrun=0, cpu_rdata=33.
- Output collision and gating:
  - cpu_wr(8'h5A) in the same cycle as the ack fall: obf_n stays 0, pa_out=5A, and the subsequent ack rise gives no intr.
  - With inte=0, a full handshake never raises intr.
- Reset and mode change:
  - rst asserted with ibf=1 and intr=1: next cycle all flags are at reset values, and pa_out=0, cpu_rdata=0.
  - Toggling dir_in mid-handshake clears the flags and keeps the latches.

Source files
------------

// File: rtl/ppi_pkg.sv
// Shared PPI definitions: data width, direction encodings and handshake flag bundle.
package ppi_pkg;

  localparam int unsigned PPI_DATA_W = 8;

  localparam logic DIR_IN  = 1'b1;
  localparam logic DIR_OUT = 1'b0;

  // Mode 1 handshake flags held per port.
  typedef struct packed {
    logic ibf;
    logic obf_n;
    logic intr;
    logic overrun;
  } hs_flags_t;

  localparam hs_flags_t HS_RESET = '{ibf: 1'b0, obf_n: 1'b1, intr: 1'b0, overrun: 1'b0};

endpackage

// File: rtl/ppi_port_a_handshake_if.sv
// Port A Mode 1 bus: control-logic strobes, CPU data and peripheral pins.
//   slave  : the handshake controller side
//   master : the control logic / peripheral side that drives it
interface ppi_port_a_handshake_if
  import ppi_pkg::*;
#(
  parameter int unsigned WIDTH = PPI_DATA_W
);

  logic             enable;
  logic             dir_in;
  logic             inte;
  logic             cpu_rd;
  logic             cpu_wr;
  logic [WIDTH-1:0] cpu_wdata;
  logic [WIDTH-1:0] cpu_rdata;
  logic [WIDTH-1:0] pa_in;
  logic [WIDTH-1:0] pa_out;
  logic             pa_oe;
  logic             stb_n;
  logic             ack_n;
  logic             ibf;
  logic             obf_n;
  logic             intr;
  logic             overrun;

  modport slave (
    input  enable, dir_in, inte, cpu_rd, cpu_wr, cpu_wdata, pa_in, stb_n, ack_n,
    output cpu_rdata, pa_out, pa_oe, ibf, obf_n, intr, overrun
  );

  modport master (
    output enable, dir_in, inte, cpu_rd, cpu_wr, cpu_wdata, pa_in, stb_n, ack_n,
    input  cpu_rdata, pa_out, pa_oe, ibf, obf_n, intr, overrun
  );

endinterface

// File: rtl/ppi_edge_det.sv
// One-flop sampler with fall/rise pulses for an already-synchronous active-low line.
//   clk, rst : clock, synchronous active-high reset (sampler resets to 1)
//   sig_i    : line to watch
//   fall_o   : current 0, previous 1
//   rise_o   : current 1, previous 0
module ppi_edge_det (
  input  logic clk,
  input  logic rst,
  input  logic sig_i,
  output logic fall_o,
  output logic rise_o
);

  logic sig_q;

  always_ff @(posedge clk) begin
    if (rst) sig_q <= 1'b1;
    else     sig_q <= sig_i;
  end

  assign fall_o = ~sig_i &  sig_q;
  assign rise_o =  sig_i & ~sig_q;

endmodule

// File: rtl/ppi_port_a_handshake.sv
// PPI Port A strobed (Mode 1) handshake controller.
//   clk, rst : clock, synchronous active-high reset
//   bus      : control strobes, CPU data, Port A pins and handshake flags
// Input mode latches pa_in on STB fall and raises ibf/intr; output mode holds
// CPU data on pa_out with obf_n and completes on ACK.
module ppi_port_a_handshake
  import ppi_pkg::*;
#(
  parameter int unsigned WIDTH = PPI_DATA_W
) (
  input  logic                   clk,
  input  logic                   rst,
  ppi_port_a_handshake_if.slave  bus
);

  hs_flags_t        flags_q, flags_d;
  logic [WIDTH-1:0] in_q, in_d;
  logic [WIDTH-1:0] out_q, out_d;
  logic [1:0]       mode_q;
  logic             mode_chg;
  logic             stb_fall, stb_rise, ack_fall, ack_rise;

  ppi_edge_det u_stb_det (
    .clk    (clk),
    .rst    (rst),
    .sig_i  (bus.stb_n),
    .fall_o (stb_fall),
    .rise_o (stb_rise)
  );

  ppi_edge_det u_ack_det (
    .clk    (clk),
    .rst    (rst),
    .sig_i  (bus.ack_n),
    .fall_o (ack_fall),
    .rise_o (ack_rise)
  );

  // Any change of enable/dir_in abandons the open handshake.
  assign mode_chg = ({bus.enable, bus.dir_in} != mode_q);

  // State registers; mode_q loads the live mode during reset so leaving reset is not a mode change.
  always_ff @(posedge clk) begin
    if (rst) begin
      flags_q <= HS_RESET;
      in_q    <= '0;
      out_q   <= '0;
      mode_q  <= {bus.enable, bus.dir_in};
    end else begin
      flags_q <= flags_d;
      in_q    <= in_d;
      out_q   <= out_d;
      mode_q  <= {bus.enable, bus.dir_in};
    end
  end

  // Next-state handshake logic.
  always_comb begin
    flags_d = flags_q;
    in_d    = in_q;
    out_d   = out_q;

    if (!bus.enable || mode_chg) begin
      flags_d = HS_RESET;
    end else if (bus.dir_in == DIR_IN) begin
      if (stb_rise && flags_q.ibf) flags_d.intr = 1'b1;
      if (bus.cpu_rd) begin
        flags_d.ibf     = 1'b0;
        flags_d.intr    = 1'b0;
        flags_d.overrun = 1'b0;
      end
      // A strobe coincident with a read refills the buffer without counting as overrun.
      if (stb_fall) begin
        in_d        = bus.pa_in;
        flags_d.ibf = 1'b1;
        if (flags_q.ibf && !bus.cpu_rd) flags_d.overrun = 1'b1;
      end
    end else begin
      if (ack_fall) flags_d.obf_n = 1'b1;
      if (ack_rise && flags_q.obf_n) flags_d.intr = 1'b1;
      // A write coincident with ACK wins: the buffer stays full with the new data.
      if (bus.cpu_wr) begin
        out_d         = bus.cpu_wdata;
        flags_d.obf_n = 1'b0;
        flags_d.intr  = 1'b0;
      end
    end

    if (!bus.inte) flags_d.intr = 1'b0;
  end

  assign bus.ibf       = flags_q.ibf;
  assign bus.obf_n     = flags_q.obf_n;
  assign bus.intr      = flags_q.intr;
  assign bus.overrun   = flags_q.overrun;
  assign bus.pa_out    = out_q;
  assign bus.pa_oe     = bus.enable & (bus.dir_in == DIR_OUT);
  assign bus.cpu_rdata = (bus.dir_in == DIR_IN) ? in_q : out_q;

endmodule

// File: tb/tb_ppi_port_a_handshake.sv
// Scoreboard bench for ppi_port_a_handshake: each step pushes the expected
// post-edge state, then the state sampled 1 time unit after the edge is popped and compared.
module tb_ppi_port_a_handshake;

  typedef struct packed {
    logic       ibf;
    logic       obf_n;
    logic       intr;
    logic       ovr;
    logic [7:0] pa_out;
    logic [7:0] rdata;
    logic       oe;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  int   total = 0;
  int   bad   = 0;
  exp_t sb_q[$];

  ppi_port_a_handshake_if #(.WIDTH(8)) bus ();

  ppi_port_a_handshake #(.WIDTH(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic ibf, input logic obf_n, input logic intr, input logic ovr,
                      input logic [7:0] pa_out, input logic [7:0] rdata, input logic oe);
    exp_t e;
    e.ibf = ibf; e.obf_n = obf_n; e.intr = intr; e.ovr = ovr;
    e.pa_out = pa_out; e.rdata = rdata; e.oe = oe;
    sb_q.push_back(e);
  endtask

  // Advance one edge and compare the DUT against the oldest scoreboard entry.
  task automatic tick(input string tag);
    exp_t e;
    @(posedge clk);
    #1;
    if (sb_q.size() == 0) begin
      total++;
      bad++;
      $display("FAIL %s: scoreboard empty", tag);
    end else begin
      e = sb_q.pop_front();
      chk({tag, ".ibf"},     32'(bus.ibf),       32'(e.ibf));
      chk({tag, ".obf_n"},   32'(bus.obf_n),     32'(e.obf_n));
      chk({tag, ".intr"},    32'(bus.intr),      32'(e.intr));
      chk({tag, ".overrun"}, 32'(bus.overrun),   32'(e.ovr));
      chk({tag, ".pa_out"},  32'(bus.pa_out),    32'(e.pa_out));
      chk({tag, ".rdata"},   32'(bus.cpu_rdata), 32'(e.rdata));
      chk({tag, ".pa_oe"},   32'(bus.pa_oe),     32'(e.oe));
    end
  endtask

  initial begin
    rst           = 1'b1;
    bus.enable    = 1'b1;
    bus.dir_in    = 1'b1;
    bus.inte      = 1'b1;
    bus.cpu_rd    = 1'b0;
    bus.cpu_wr    = 1'b0;
    bus.cpu_wdata = 8'h00;
    bus.pa_in     = 8'h00;
    bus.stb_n     = 1'b1;
    bus.ack_n     = 1'b1;

    push(0, 1, 0, 0, 8'h00, 8'h00, 0); tick("reset0");
    push(0, 1, 0, 0, 8'h00, 8'h00, 0); tick("reset1");
    rst = 1'b0;

    // Strobed input, inte=1
    bus.pa_in = 8'hA5; bus.stb_n = 1'b0;
    push(1, 1, 0, 0, 8'h00, 8'hA5, 0); tick("in_fall");
    push(1, 1, 0, 0, 8'h00, 8'hA5, 0); tick("in_low");
    bus.stb_n = 1'b1;
    push(1, 1, 1, 0, 8'h00, 8'hA5, 0); tick("in_rise");
    bus.cpu_rd = 1'b1;
    push(0, 1, 0, 0, 8'h00, 8'hA5, 0); tick("in_rd");
    bus.cpu_rd = 1'b0;

    // Overrun, then read coincident with a third strobe
    bus.pa_in = 8'h11; bus.stb_n = 1'b0;
    push(1, 1, 0, 0, 8'h00, 8'h11, 0); tick("ovr_s1");
    bus.stb_n = 1'b1;
    push(1, 1, 1, 0, 8'h00, 8'h11, 0); tick("ovr_r1");
    bus.pa_in = 8'h22; bus.stb_n = 1'b0;
    push(1, 1, 1, 1, 8'h00, 8'h22, 0); tick("ovr_s2");
    bus.stb_n = 1'b1;
    push(1, 1, 1, 1, 8'h00, 8'h22, 0); tick("ovr_r2");
    bus.pa_in = 8'h33; bus.stb_n = 1'b0; bus.cpu_rd = 1'b1;
    push(1, 1, 0, 0, 8'h00, 8'h33, 0); tick("rd_stb");
    bus.cpu_rd = 1'b0; bus.stb_n = 1'b1;
    push(1, 1, 1, 0, 8'h00, 8'h33, 0); tick("rd_stb_rise");
    bus.cpu_rd = 1'b1;
    push(0, 1, 0, 0, 8'h00, 8'h33, 0); tick("rd_clear");
    bus.cpu_rd = 1'b0;

    // Switch to output mode; a stray cpu_rd-free write test follows
    bus.dir_in = 1'b0;
    push(0, 1, 0, 0, 8'h00, 8'h00, 1); tick("to_out");
    bus.cpu_wr = 1'b1; bus.cpu_wdata = 8'h3C;
    push(0, 0, 0, 0, 8'h3C, 8'h3C, 1); tick("out_wr");
    bus.cpu_wr = 1'b0; bus.ack_n = 1'b0;
    push(0, 1, 0, 0, 8'h3C, 8'h3C, 1); tick("out_ack_fall");
    bus.ack_n = 1'b1;
    push(0, 1, 1, 0, 8'h3C, 8'h3C, 1); tick("out_ack_rise");

    // Write coincident with ACK fall: write wins, following rise gives no intr
    bus.cpu_wr = 1'b1; bus.cpu_wdata = 8'h5A; bus.ack_n = 1'b0;
    push(0, 0, 0, 0, 8'h5A, 8'h5A, 1); tick("coll_wr");
    bus.cpu_wr = 1'b0; bus.ack_n = 1'b1;
    push(0, 0, 0, 0, 8'h5A, 8'h5A, 1); tick("coll_rise");

    // inte=0: full handshake never raises intr
    bus.inte = 1'b0; bus.ack_n = 1'b0;
    push(0, 1, 0, 0, 8'h5A, 8'h5A, 1); tick("noint_fall");
    bus.ack_n = 1'b1;
    push(0, 1, 0, 0, 8'h5A, 8'h5A, 1); tick("noint_rise");

    // intr raised then dropped by inte=0, not restored by inte=1
    bus.inte = 1'b1; bus.cpu_wr = 1'b1; bus.cpu_wdata = 8'h77;
    push(0, 0, 0, 0, 8'h77, 8'h77, 1); tick("ie_wr");
    bus.cpu_wr = 1'b0; bus.ack_n = 1'b0;
    push(0, 1, 0, 0, 8'h77, 8'h77, 1); tick("ie_fall");
    bus.ack_n = 1'b1;
    push(0, 1, 1, 0, 8'h77, 8'h77, 1); tick("ie_rise");
    bus.inte = 1'b0;
    push(0, 1, 0, 0, 8'h77, 8'h77, 1); tick("ie_off");
    bus.inte = 1'b1;
    push(0, 1, 0, 0, 8'h77, 8'h77, 1); tick("ie_on");

    // dir_in toggle mid-handshake clears flags, keeps both latches
    bus.cpu_wr = 1'b1; bus.cpu_wdata = 8'h99;
    push(0, 0, 0, 0, 8'h99, 8'h99, 1); tick("dir_wr");
    bus.cpu_wr = 1'b0; bus.dir_in = 1'b1;
    push(0, 1, 0, 0, 8'h99, 8'h33, 0); tick("dir_to_in");
    bus.dir_in = 1'b0;
    push(0, 1, 0, 0, 8'h99, 8'h99, 1); tick("dir_to_out");
    bus.dir_in = 1'b1;
    push(0, 1, 0, 0, 8'h99, 8'h33, 0); tick("dir_back_in");

    // Reset during open input handshake with intr pending
    bus.pa_in = 8'h44; bus.stb_n = 1'b0;
    push(1, 1, 0, 0, 8'h99, 8'h44, 0); tick("rst_fall");
    bus.stb_n = 1'b1;
    push(1, 1, 1, 0, 8'h99, 8'h44, 0); tick("rst_rise");
    rst = 1'b1;
    push(0, 1, 0, 0, 8'h00, 8'h00, 0); tick("rst_apply");
    rst = 1'b0;

    // enable=0 holds flags at reset and ignores strobes
    bus.enable = 1'b0; bus.pa_in = 8'h55; bus.stb_n = 1'b0;
    push(0, 1, 0, 0, 8'h00, 8'h00, 0); tick("dis_fall");
    bus.stb_n = 1'b1;
    push(0, 1, 0, 0, 8'h00, 8'h00, 0); tick("dis_rise");
    bus.dir_in = 1'b0;
    push(0, 1, 0, 0, 8'h00, 8'h00, 0); tick("dis_out_oe");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
